// File: rtl/dram_multi_bist_pkg.sv
// Shared types and helpers for the multi-bank distributed-RAM self-test.
package dram_bist_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR0   = 3'd1,
    RD0   = 3'd2,
    WR1   = 3'd3,
    RD1   = 3'd4,
    DRAIN = 3'd5,
    DONE  = 3'd6
  } state_e;

  // Pattern word for (address, channel); caller truncates to DATA_W.
  function automatic logic [7:0] pat(input int a, input int c, input logic inv);
    logic [7:0] v;
    v = 8'(a + 3 * c);
    return inv ? ~v : v;
  endfunction

  function automatic logic [4:0] popcnt(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) n = n + 5'(v[i]);
    return n;
  endfunction

  function automatic int err_w(input int nch, input int aw);
    return $clog2(2 * (2 ** aw) * nch + 1);
  endfunction

endpackage

// File: rtl/dram_multi_bist_if.sv
// Control/status and manual-access bundle of the DRAM self-test block.
interface dram_multi_bist_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 2,
  parameter int ADDR_W = 5,
  parameter int ERR_W  = dram_bist_pkg::err_w(NUM_CH, ADDR_W)
) ();
  logic                       start;
  logic [NUM_CH*DATA_W-1:0]   inj_mask;
  logic                       man_we;
  logic [ADDR_W-1:0]          man_addr;
  logic [NUM_CH*DATA_W-1:0]   man_din;
  logic [NUM_CH*DATA_W-1:0]   man_dout;
  logic                       busy;
  logic                       done;
  logic                       pass;
  logic [ERR_W-1:0]           err_count;
  logic [ADDR_W-1:0]          first_err_addr;

  modport master (output start, inj_mask, man_we, man_addr, man_din,
                  input  man_dout, busy, done, pass, err_count, first_err_addr);
  modport slave  (input  start, inj_mask, man_we, man_addr, man_din,
                  output man_dout, busy, done, pass, err_count, first_err_addr);
endinterface

// File: rtl/dram_multi_bist_bank.sv
// One channel of LUT-RAM: sync write, two async read ports (BIST and manual).
module dram_bank #(
  parameter int DATA_W = 2,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b
);
  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];
endmodule

// File: rtl/dram_multi_bist.sv
// NUM_CH-bank distributed-RAM march test (P then ~P) with manual access port.
// Optional macro BIST_ABORT_ON_ERR_EN: stop at the first registered mismatch.
module dram_multi_bist
  import dram_bist_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 2,
  parameter int ADDR_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  dram_multi_bist_if.slave bus
);
  localparam int W     = NUM_CH * DATA_W;
  localparam int ERR_W = err_w(NUM_CH, ADDR_W);

  state_e            state;
  logic [ADDR_W-1:0] addr, addr_q, waddr;
  logic [NUM_CH-1:0] mis, mis_q;
  logic [W-1:0]      rdata, mdata, wdata;
  logic [ERR_W-1:0]  err_count;
  logic [ADDR_W-1:0] first_err_addr;
  logic              busy, bist_wr, cmp_vld, cmp_vld_q, inv, last, abort, we, seen, pass, launch;

  assign busy    = (state == WR0) || (state == RD0) || (state == WR1) || (state == RD1);
  assign bist_wr = (state == WR0) || (state == WR1);
  assign cmp_vld = (state == RD0) || (state == RD1);
  assign inv     = (state == WR1) || (state == RD1);
  assign last    = &addr;
  assign launch  = ((state == IDLE) || (state == DONE)) && bus.start;
  assign we      = bist_wr || (!busy && bus.man_we);
  assign waddr   = bist_wr ? addr : bus.man_addr;

`ifdef BIST_ABORT_ON_ERR_EN
  assign abort = cmp_vld_q && (|mis_q);
`else
  assign abort = 1'b0;
`endif

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [DATA_W-1:0] exp_w;
    assign exp_w = DATA_W'(pat(int'(addr), c, inv));
    assign wdata[c*DATA_W +: DATA_W] = bist_wr
      ? exp_w ^ ((state == WR0) ? bus.inj_mask[c*DATA_W +: DATA_W] : '0)
      : bus.man_din[c*DATA_W +: DATA_W];
    assign mis[c] = cmp_vld && (rdata[c*DATA_W +: DATA_W] != exp_w);

    dram_bank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_bank (
      .clk     (clk),
      .we      (we),
      .waddr   (waddr),
      .wdata   (wdata[c*DATA_W +: DATA_W]),
      .raddr_a (addr),
      .rdata_a (rdata[c*DATA_W +: DATA_W]),
      .raddr_b (bus.man_addr),
      .rdata_b (mdata[c*DATA_W +: DATA_W])
    );
  end

  // Phases are consecutive encodings WR0..RD1 -> DRAIN; DRAIN reuses addr as a 2-cycle timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      addr  <= '0;
    end else begin
      case (state)
        IDLE, DONE: if (bus.start) begin
          state <= WR0;
          addr  <= '0;
        end
        DRAIN: begin
          addr <= addr + 1'b1;
          if (addr[0]) begin
            state <= DONE;
            addr  <= '0;
          end
        end
        default: begin
          addr <= addr + 1'b1;
          if (abort) begin
            state <= DONE;
            addr  <= '0;
          end else if (last) begin
            state <= state_e'(state + 3'd1);
          end
        end
      endcase
    end
  end

  // Compare pipeline: mismatch flags registered, then accumulated a cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mis_q          <= '0;
      cmp_vld_q      <= 1'b0;
      addr_q         <= '0;
      err_count      <= '0;
      first_err_addr <= '0;
      seen           <= 1'b0;
      pass           <= 1'b0;
      bus.man_dout   <= '0;
    end else begin
      bus.man_dout <= mdata;
      mis_q        <= mis;
      cmp_vld_q    <= cmp_vld && !abort;
      addr_q       <= addr;
      if (launch) begin
        err_count      <= '0;
        first_err_addr <= '0;
        seen           <= 1'b0;
        pass           <= 1'b0;
      end else begin
        if (cmp_vld_q) err_count <= err_count + ERR_W'(popcnt(16'(mis_q)));
        if (cmp_vld_q && (|mis_q) && !seen) begin
          first_err_addr <= addr_q;
          seen           <= 1'b1;
        end
        if ((state == DRAIN) && addr[0]) pass <= (err_count == '0);
      end
    end
  end

  assign bus.busy           = busy;
  assign bus.done           = (state == DONE);
  assign bus.pass           = pass;
  assign bus.err_count      = err_count;
  assign bus.first_err_addr = first_err_addr;
endmodule
